pipe_adder: RTL and testbench



---
 rtl/pipe_adder.sv | 121 ++++++++++++
 tb/tb_pipe_adder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder: the carry chain is cut into STAGES slices, one per register stage,
// with valid/ready flow control. Define PIPE_ADDER_SUB_EN to add the sub (subtract-select) port.
module pipe_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per stage: r_a holds summed slices 0..k plus the still-unsummed upper A slices.
    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic             r_c     [STAGES];
    logic             r_ovf;

    logic [STAGES-1:0] w_load;
    logic              w_v_in     [STAGES];
    logic [WIDTH-1:0]  w_a_in     [STAGES];
    logic [WIDTH-1:0]  w_b_in     [STAGES];
    logic              w_c_in     [STAGES];
    logic [SW:0]       w_slice    [STAGES];
    logic [WIDTH-1:0]  w_a_next   [STAGES];
    logic [WIDTH-1:0]  w_op2;
    logic              w_ovf_last;

`ifdef PIPE_ADDER_SUB_EN
    assign w_op2 = sub ? ~operand2 : operand2;
`else
    assign w_op2 = operand2;
`endif

    // A stage loads when empty or when its occupant moves on this cycle.
    always_comb begin
        w_load       = '0;
        w_load[LAST] = !r_valid[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            w_load[k] = !r_valid[k] || w_load[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
        if (k == 0) begin : g_first
            assign w_v_in[k] = in_valid;
            assign w_a_in[k] = operand1;
            assign w_b_in[k] = w_op2;
            assign w_c_in[k] = cin;
        end else begin : g_next
            assign w_v_in[k] = r_valid[k-1];
            assign w_a_in[k] = r_a[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_c_in[k] = r_c[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_slice[k]  = {1'b0, w_a_in[k][k*SW +: SW]}
                        + {1'b0, w_b_in[k][k*SW +: SW]}
                        + {{SW{1'b0}}, w_c_in[k]};
            w_a_next[k] = w_a_in[k];
            w_a_next[k][k*SW +: SW] = w_slice[k][SW-1:0];
        end
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at the top bit.
    assign w_ovf_last = w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1]
                      ^ w_slice[LAST][SW-1]   ^ w_slice[LAST][SW];

    // NOTE: datapath registers are reset too, so result/cout/overflow read 0 as soon as resetn falls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_c[k]     <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the pre-edge value of its upstream neighbour.
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_v_in[k];
                    if (w_v_in[k]) begin
                        r_a[k] <= w_a_next[k];
                        r_b[k] <= w_b_in[k];
                        r_c[k] <= w_slice[k][SW];
                    end
                end
            end
            if (w_load[LAST] && w_v_in[LAST]) begin
                r_ovf <= w_ovf_last;
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[LAST];
    assign result    = r_a[LAST];
    assign cout      = r_c[LAST];
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=64, STAGES=4) using an in-order scoreboard queue.
module tb_pipe_adder;

    localparam int W = 64;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] operand1 = '0;
    logic [W-1:0] operand2 = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
`ifdef PIPE_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   full;
        exp_t         e;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        e.r  = full[W-1:0];
        e.c  = full[W];
        e.o  = (a[W-1] == bb[W-1]) && (e.r[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic logic [W-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // One cycle: drive at the falling edge, sample 1 time unit later, then wait for the next falling edge.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input logic ordy,
                         output logic acc_in, output logic acc_out, output logic rdy,
                         output exp_t got);
        in_valid  = v;
        operand1  = a;
        operand2  = b;
        cin       = c;
        out_ready = ordy;
`ifdef PIPE_ADDER_SUB_EN
        sub       = s;
`endif
        #1;
        rdy     = in_ready;
        acc_in  = in_valid && in_ready;
        acc_out = out_valid && out_ready;
        got.r   = result;
        got.c   = cout;
        got.o   = overflow;
        if (acc_in) sb.push_back(model(a, b, c, s));
        @(negedge clk);
    endtask

    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                            input logic s, output int lat, output exp_t got, output logic accepted);
        logic ai, ao, rdy;
        exp_t g;
        drive(1'b1, a, b, c, s, 1'b1, ai, ao, rdy, g);
        accepted = ai;
        lat      = -1;
        got      = '0;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ai, ao, rdy, g);
            if (ao) begin
                lat = i;
                got = g;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if ({out_valid, result, cout, overflow} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got valid=%b result=%h cout=%b ovf=%b, want all 0",
                     out_valid, result, cout, overflow);
        else n_pass++;
        resetn = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s, input exp_t want);
        int   lat;
        exp_t got, e;
        logic acc;
        send_one(a, b, c, s, lat, got, acc);
        n_checks++;
        if (!acc || lat != S) $display("FAIL %s_latency: accepted=%b latency=%0d want 1/%0d", name, acc, lat, S);
        else n_pass++;
        n_checks++;
        if (lat < 0) begin
            $display("FAIL %s_result: no output within cycle budget", name);
        end else begin
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            if (got !== want || got !== e)
                $display("FAIL %s_result: got r=%h c=%b o=%b want r=%h c=%b o=%b",
                         name, got.r, got.c, got.o, want.r, want.c, want.o);
            else n_pass++;
        end
        sb.delete();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b;
        logic         c, ai, ao, rdy, ordy;
        exp_t         got, e;
        int           sent = 0, recv = 0, cyc = 0, bad_stall = 0;
        a = rand64(); b = rand64(); c = 1'($urandom_range(0, 1));
        while ((sent < 20 || recv < 20) && cyc < 200) begin
            ordy = !(cyc >= 3 && cyc <= 12);
            drive(sent < 20, a, b, c, 1'b0, ordy, ai, ao, rdy, got);
            if (ao) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL bp_result: unexpected output r=%h", got.r);
                end else begin
                    e = sb.pop_front();
                    if (got !== e)
                        $display("FAIL bp_result[%0d]: got r=%h c=%b o=%b want r=%h c=%b o=%b",
                                 recv, got.r, got.c, got.o, e.r, e.c, e.o);
                    else n_pass++;
                end
                recv++;
            end
            if (cyc >= 4 && cyc <= 12 && (rdy !== 1'b0 || sb.size() != S)) bad_stall++;
            if (ai) begin
                sent++;
                a = rand64(); b = rand64(); c = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        n_checks++;
        if (bad_stall != 0) $display("FAIL bp_stall: %0d stalled cycles not full or in_ready=1, want 0", bad_stall);
        else n_pass++;
        n_checks++;
        if (recv != 20 || sb.size() != 0)
            $display("FAIL bp_count: received %0d left %0d, want 20 and 0", recv, sb.size());
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic ai, ao, rdy;
        exp_t got, e;
        int   recv = 0, gaps = 0, errs = 0;
        for (int i = 0; i < 1000 + S; i++) begin
            drive(i < 1000, rand64(), rand64(), 1'($urandom_range(0, 1)), 1'b0, 1'b1, ai, ao, rdy, got);
            if (i >= S && !ao) gaps++;
            if (ao) begin
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_checks++;
                if (got !== e) begin
                    errs++;
                    if (errs <= 5)
                        $display("FAIL stream_result[%0d]: got r=%h c=%b o=%b want r=%h c=%b o=%b",
                                 recv, got.r, got.c, got.o, e.r, e.c, e.o);
                end else n_pass++;
                recv++;
            end
        end
        n_checks++;
        if (gaps != 0 || recv != 1000) $display("FAIL stream_rate: gaps=%0d received=%0d want 0/1000", gaps, recv);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        logic ai, ao, rdy;
        exp_t got, e, want;
        int   stale = 0, lat;
        logic acc;
        for (int i = 0; i < 3; i++)
            drive(1'b1, rand64() | 64'h1, 64'h10, 1'b0, 1'b0, 1'b0, ai, ao, rdy, got);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ai, ao, rdy, got);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || result !== e.r)
            $display("FAIL mid_pre: got valid=%b r=%h want 1 r=%h", out_valid, result, e.r);
        else n_pass++;
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, result, cout, overflow} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0})
            $display("FAIL mid_reset: got valid=%b result=%h cout=%b ovf=%b, want all 0",
                     out_valid, result, cout, overflow);
        else n_pass++;
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ai, ao, rdy, got);
            if (ao) stale++;
        end
        n_checks++;
        if (stale != 0) $display("FAIL mid_stale: %0d stale outputs, want 0", stale);
        else n_pass++;
        want = model(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
        send_one(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0, lat, got, acc);
        n_checks++;
        if (!acc || lat != S || got !== want)
            $display("FAIL mid_after: acc=%b lat=%0d r=%h want 1/%0d r=%h", acc, lat, got.r, S, want.r);
        else n_pass++;
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_directed("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                      '{r: 64'h0, c: 1'b1, o: 1'b0});
        test_directed("overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                      '{r: 64'h8000_0000_0000_0000, c: 1'b0, o: 1'b1});
        test_backpressure();
        test_streaming();
        test_reset_midflight();
`ifdef PIPE_ADDER_SUB_EN
        test_directed("subtract", 64'd5, 64'd7, 1'b1, 1'b1,
                      '{r: 64'hFFFF_FFFF_FFFF_FFFE, c: 1'b0, o: 1'b0});
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
